// File: rtl/tpu_isa_pkg.sv
// tpu_isa_pkg: shared fetch-stage types and default widths
package tpu_isa_pkg;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int INSTR_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry instruction/pc buffer with flush and same-cycle push+pop
module fetch_fifo
  import tpu_isa_pkg::*;
#(
  parameter int DW = INSTR_WIDTH_DEF,
  parameter int AW = CNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_pc,
  output logic          empty,
  output logic [1:0]    count
);
  logic [DW-1:0] data_q [2];
  logic [AW-1:0] pc_q [2];
  logic rd_ptr, wr_ptr, do_pop, full;
  assign empty = count == 2'd0;
  assign full = count == 2'd2;
  assign do_pop = pop & ~empty;
  assign head_data = empty ? '0 : data_q[rd_ptr];
  assign head_pc = empty ? '0 : pc_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        pc_q[wr_ptr] <= push_pc;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(do_pop);
    end
  end
  overflow: assert property (@(posedge clk) disable iff (!nrst) !(push && full && !pop && !flush));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited instruction fetch with redirect, halt/drain and 2-entry buffer
module instr_fetch
  import tpu_isa_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   start_addr,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [CNT_WIDTH-1:0]   redirect_addr,
  output logic                   imem_en,
  output logic [CNT_WIDTH-1:0]   imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [CNT_WIDTH-1:0]   instr_pc,
  output logic                   busy
);
  fetch_state_t state, state_n;
  logic [CNT_WIDTH-1:0] pc, pc_n, flight_pc;
  logic in_flight, issue, kill, pop, empty;
  logic [1:0] count;
  logic [2:0] credit;
  assign busy = state != IDLE;
  assign kill = redirect_valid & busy;
  assign instr_valid = ~empty;
  assign pop = instr_valid & instr_ready;
  assign credit = {1'b0, count} + 3'(in_flight) - 3'(pop);
  assign imem_en = issue;
  assign imem_addr = issue ? pc : '0;
  always_comb begin
    issue = state == FETCH && !halt && !redirect_valid && credit < 3'd2;
    state_n = state == IDLE ? (start && !halt ? FETCH : IDLE) :
              state == FETCH ? (halt ? DRAIN : FETCH) :
              (!in_flight && empty ? IDLE : DRAIN);
    pc_n = state == IDLE && start && !halt ? start_addr :
           state == FETCH && redirect_valid ? redirect_addr :
           issue ? pc + CNT_WIDTH'(1) : pc;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      pc <= '0;
      in_flight <= 1'b0;
      flight_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      in_flight <= issue;
      flight_pc <= pc;
    end
  end
  fetch_fifo #(.DW(INSTR_WIDTH), .AW(CNT_WIDTH)) u_fifo (
    .clk(clk),
    .nrst(nrst),
    .flush(kill),
    .push(in_flight & ~kill),
    .push_data(imem_rdata),
    .push_pc(flight_pc),
    .pop(pop),
    .head_data(instr_data),
    .head_pc(instr_pc),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a queue-based reference model
module tb_instr_fetch;
  logic clk, nrst, start, halt, redirect_valid, imem_en, instr_valid, instr_ready, busy;
  logic [7:0] start_addr, redirect_addr, imem_addr, instr_pc;
  logic [15:0] imem_rdata, instr_data;
  int n_chk = 0, n_fail = 0;
  int ms, mfv;
  logic [7:0] mpc, mfpc, last_addr;
  logic last_en;
  logic [7:0] mq[$];
  logic [23:0] sb[$];
  logic [2:0] lat;

  instr_fetch dut (
    .clk(clk), .nrst(nrst), .start(start), .start_addr(start_addr), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [7:0] a);
    return {8'h00, a} ^ 16'hA5A5;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic [7:0] sa, input logic hl, input logic rv,
                      input logic [7:0] ra, input logic rdy, input logic rn);
    int pop, iss, nms;
    logic [7:0] hd;
    @(negedge clk);
    imem_rdata = last_en ? word(last_addr) : 16'($urandom);
    start = st; start_addr = sa; halt = hl; redirect_valid = rv;
    redirect_addr = ra; instr_ready = rdy; nrst = rn;
    #1;
    last_en = imem_en;
    last_addr = imem_addr;
    if (!rn) begin
      ms = 0; mpc = 8'h00; mfv = 0; mq.delete();
      return;
    end
    hd = mq.size() > 0 ? mq[0] : 8'h00;
    pop = (mq.size() > 0 && rdy) ? 1 : 0;
    iss = (ms == 1 && !hl && !rv && mq.size() + mfv - pop < 2) ? 1 : 0;
    chk("imem_en", 32'(imem_en), 32'(iss));
    chk("imem_addr", 32'(imem_addr), iss != 0 ? 32'(mpc) : 32'd0);
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    chk("instr_pc", 32'(instr_pc), 32'(hd));
    chk("instr_data", 32'(instr_data), mq.size() > 0 ? 32'(word(hd)) : 32'd0);
    chk("busy", 32'(busy), 32'(ms != 0));
    if (pop != 0) sb.push_back({hd, word(hd)});
    nms = ms == 0 ? (st && !hl ? 1 : 0) : ms == 1 ? (hl ? 2 : 1) : (mfv == 0 && mq.size() == 0 ? 0 : 2);
    if (rv && ms != 0) mq.delete();
    else begin
      if (pop != 0) void'(mq.pop_front());
      if (mfv != 0) mq.push_back(mfpc);
    end
    mfpc = mpc;
    mfv = iss;
    if (ms == 0 && st && !hl) mpc = sa;
    else if (ms == 1 && rv) mpc = ra;
    else if (iss != 0) mpc = mpc + 8'd1;
    ms = nms;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00, rdy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (ms != 0 || busy); i++) step(0, 8'h00, 0, 0, 8'h00, 1, 1);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_flight(input logic [7:0] a);
    int i;
    for (i = 0; i < 12 && !(mfv != 0 && mfpc == a); i++) step(0, 8'h00, 0, 0, 8'h00, 1, 1);
    if (i == 12) begin
      n_chk++; n_fail++;
      $display("FAIL wait_flight: got no read of %h in flight expected one within 12 cycles", a);
    end
  endtask

  initial begin : monitor
    logic [23:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (nrst && instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL xfer_unexpected: got pc %h expected no transfer", instr_pc);
        end else begin
          e = sb.pop_front();
          chk("xfer_pc", 32'(instr_pc), 32'(e[23:16]));
          chk("xfer_data", 32'(instr_data), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    clk = 0; nrst = 0; start = 0; halt = 0; redirect_valid = 0; instr_ready = 0;
    start_addr = 0; redirect_addr = 0; imem_rdata = 0;
    last_en = 0; last_addr = 0; ms = 0; mfv = 0; mpc = 0; mfpc = 0;
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    run(2, 1);
    step(1, 8'h10, 0, 0, 8'h00, 1, 1);
    for (int k = 2; k >= 0; k--) begin
      step(0, 8'h00, 0, 0, 8'h00, 1, 1);
      lat[k] = instr_valid;
    end
    chk("start_latency", 32'(lat), 32'(3'b001));
    wait_flight(8'h13);
    step(0, 8'h00, 0, 1, 8'h40, 1, 1);
    run(4, 1);
    run(5, 0);
    chk("bp_no_issue", 32'(imem_en), 32'd0);
    run(6, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);
    drain();
    step(0, 8'h00, 0, 1, 8'h55, 1, 1);
    step(1, 8'hFE, 0, 0, 8'h00, 1, 1);
    step(1, 8'h33, 0, 0, 8'h00, 1, 1);
    run(7, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);
    drain();
    step(1, 8'h20, 0, 0, 8'h00, 1, 1);
    run(5, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
    run(1, 1);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    step(1, 8'h30, 0, 0, 8'h00, 1, 1);
    run(6, 1);
    step(0, 8'h00, 1, 1, 8'h70, 1, 1);
    drain();
    for (int i = 0; i < 800; i++) begin
      logic rn;
      rn = $urandom_range(99) != 0;
      step($urandom_range(4) == 0, 8'($urandom), $urandom_range(29) == 0, $urandom_range(19) == 0,
           8'($urandom), rn && $urandom_range(9) < 7, rn);
    end
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);
    drain();
    run(2, 1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, the instruction-address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, the instruction-word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port nrst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, begin fetching at start_addr (honoured in IDLE only).
REQ-006 SHALL have port start_addr, input, CNT_WIDTH, the first fetch address.
REQ-007 SHALL have port halt, input, 1, stop issuing new fetches.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump: flush and refetch.
REQ-009 SHALL have port redirect_addr, input, CNT_WIDTH, the redirect target.
REQ-010 SHALL have port imem_en, output, 1, instruction-memory read strobe.
REQ-011 SHALL have port imem_addr, output, CNT_WIDTH, the read address (current PC).
REQ-012 SHALL have port imem_rdata, input, INSTR_WIDTH, read data, valid exactly 1 cycle after imem_en.
REQ-013 SHALL have port instr_valid, output, 1, an instruction is presented to the decoder.
REQ-014 SHALL have port instr_ready, input, 1, the decoder accepts; transfer when valid and ready are both high.
REQ-015 SHALL have port instr_data, output, INSTR_WIDTH, the instruction word.
REQ-016 SHALL have port instr_pc, output, CNT_WIDTH, the address of instr_data.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH and DRAIN.
REQ-019 SHALL take these transitions: IDLE -start-> FETCH with pc<=start_addr; FETCH -halt-> DRAIN; DRAIN -> IDLE when no read is in flight and the buffer is empty.
REQ-020 SHALL hold an internal PC register that, on each issue, updates pc<=pc+1 modulo 2^CNT_WIDTH (all-ones wraps to 0).
REQ-021 SHALL buffer returned words with their PC in a 2-entry FIFO.
REQ-022 SHALL, in FETCH, drive imem_en=1 and imem_addr=pc only when (occupancy + in_flight - pop_this_cycle) < 2; otherwise imem_en=0.
REQ-023 SHALL sustain one instruction per cycle while instr_ready stays high.
REQ-024 SHALL present the FIFO head: instr_valid = FIFO not empty, with instr_data and instr_pc from the head entry.
REQ-025 SHALL keep instr_data and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-026 SHALL meet this start latency: start sampled at edge T -> imem_en=1 with addr=start_addr in cycle T+1 -> instr_valid=1 in cycle T+3.
REQ-027 SHALL, on redirect_valid in FETCH, flush the FIFO, mark any in-flight read as killed (its data is discarded on return), and set pc<=redirect_addr, with no issue in the redirect cycle; first issue of redirect_addr in the next cycle.
REQ-028 SHALL ignore redirect_valid in IDLE.
REQ-029 SHALL, on redirect_valid in DRAIN, only flush and kill.
REQ-030 SHALL, when redirect_valid and halt are both high, apply the flush/kill and enter DRAIN with no further issue.
REQ-031 SHALL, in DRAIN, issue no new reads and deliver the in-flight word and buffered words normally.
REQ-032 SHALL ignore start when not in IDLE.
REQ-033 SHALL, when halt is high in IDLE, remain in IDLE.
REQ-034 SHALL, when the FIFO is full, never write to it (guaranteed by the credit rule); an overflow is a design error and SHALL be asserted in simulation.

Reset
REQ-035 SHALL, when nrst=0 at a clock edge, set state=IDLE, pc=0, FIFO empty, in-flight flag and kill flag cleared.
REQ-036 SHALL drive these outputs during and after reset: imem_en=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0.
REQ-037 SHALL, on reset mid-operation, discard any read returning in the cycle after reset.

Structure
REQ-038 SHALL define fetch_state_t (IDLE/FETCH/DRAIN) and the default widths in shared package tpu_isa_pkg.
REQ-039 SHALL place the 2-entry buffer (data+pc, push/pop, full/empty, flush, same-cycle push+pop at occupancy 1 or 2 permitted) in sub-module fetch_fifo.

Verification
REQ-040 SHALL verify start with start_addr=0x10, imem returning word=addr^0xA5A5, instr_ready=1 -> instr_valid from T+3, instr_pc 0x10,0x11,0x12... one per cycle.
REQ-041 SHALL verify backpressure: instr_ready=0 for 5 cycles mid-stream -> imem_en stops after occupancy 2, no word lost or duplicated, order preserved on release.
REQ-042 SHALL verify redirect to 0x40 while a read of 0x13 is in flight -> 0x13 is never presented, next instr_pc=0x40.
REQ-043 SHALL verify wrap: start_addr=0xFE -> instr_pc sequence 0xFE,0xFF,0x00,0x01.
REQ-044 SHALL verify halt with 1 in flight and 1 buffered -> both delivered, imem_en=0, then busy=0 and state IDLE.
REQ-045 SHALL verify nrst=0 for one cycle mid-stream -> all outputs 0 next cycle, the returning read is dropped, and a new start works from start_addr.
